pipelined_cond_sum_adder: RTL

//   Parametrised, 2-stage pipelined conditional-sum adder/subtractor with valid/ready flow control.

---
 rtl/alu_pkg.sv | 16 +
 rtl/cond_sum_block.sv | 42 ++++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_cond_sum_adder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath geometry, block-count helper and op encoding.
package alu_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_BLOCK_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of conditional-sum blocks for a given operand width.
    function automatic int unsigned num_blocks(input int unsigned width,
                                               input int unsigned block_w);
        return width / block_w;
    endfunction

endpackage

// File: rtl/cond_sum_block.sv
// One conditional-sum block: two parallel ripple chains, one assuming carry-in 0 and one carry-in 1.
module cond_sum_block
    import alu_pkg::*;
#(
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    output logic [BLOCK_W-1:0] sum0,
    output logic               carry0,
    output logic [BLOCK_W-1:0] sum1,
    output logic               carry1
);

    logic [BLOCK_W:0] chain0;
    logic [BLOCK_W:0] chain1;

    assign chain0[0] = 1'b0;
    assign chain1[0] = 1'b1;

    // Dual ripple of full-adder cells, one per assumed carry-in.
    for (genvar i = 0; i < int'(BLOCK_W); i++) begin : g_bit
        full_adder u_fa0 (
            .a  (a[i]),
            .b  (b[i]),
            .ci (chain0[i]),
            .s  (sum0[i]),
            .co (chain0[i+1])
        );
        full_adder u_fa1 (
            .a  (a[i]),
            .b  (b[i]),
            .ci (chain1[i]),
            .s  (sum1[i]),
            .co (chain1[i+1])
        );
    end

    assign carry0 = chain0[BLOCK_W];
    assign carry1 = chain1[BLOCK_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the conditional-sum blocks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_cond_sum_adder.sv
// Two-stage pipelined conditional-sum adder/subtractor with valid/ready flow control.
// Stage 1 captures per-block sum/carry pairs; stage 2 resolves block carries with a mux chain.
module pipelined_cond_sum_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NB = num_blocks(WIDTH, BLOCK_W);

    if ((WIDTH % BLOCK_W) != 0 || WIDTH < BLOCK_W) begin : g_bad_cfg
        $error("pipelined_cond_sum_adder: WIDTH must be a non-zero multiple of BLOCK_W");
    end

    // Handshake
    logic s1_valid;
    logic s2_adv;
    logic in_fire;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign in_fire  = in_valid & in_ready;

    // Operand conditioning for subtraction
    logic [WIDTH-1:0] yy;
    logic             c_in0;

    assign yy    = (sub == OP_SUB) ? ~y : y;
    assign c_in0 = (sub == OP_SUB) ? 1'b1 : cin;

    // Per-block precomputed pairs
    logic [NB-1:0][BLOCK_W-1:0] b_sum0;
    logic [NB-1:0][BLOCK_W-1:0] b_sum1;
    logic [NB-1:0]              b_c0;
    logic [NB-1:0]              b_c1;

    for (genvar k = 0; k < int'(NB); k++) begin : g_blk
        cond_sum_block #(
            .BLOCK_W (BLOCK_W)
        ) u_blk (
            .a      (x[k*BLOCK_W +: BLOCK_W]),
            .b      (yy[k*BLOCK_W +: BLOCK_W]),
            .sum0   (b_sum0[k]),
            .carry0 (b_c0[k]),
            .sum1   (b_sum1[k]),
            .carry1 (b_c1[k])
        );
    end

    // Block 0 already knows its real carry-in, so its resolved result replaces the cin=0 slot.
    logic [NB-1:0][BLOCK_W-1:0] nxt_sum0;
    logic [NB-1:0]              nxt_c0;

    always_comb begin
        nxt_sum0    = b_sum0;
        nxt_c0      = b_c0;
        nxt_sum0[0] = c_in0 ? b_sum1[0] : b_sum0[0];
        nxt_c0[0]   = c_in0 ? b_c1[0]   : b_c0[0];
    end

    // Stage 1 registers
    logic [NB-1:0][BLOCK_W-1:0] s1_sum0;
    logic [NB-1:0][BLOCK_W-1:0] s1_sum1;
    logic [NB-1:0]              s1_c0;
    logic [NB-1:0]              s1_c1;
    logic                       s1_x_msb;
    logic                       s1_yy_msb;

    // Stage 1: capture precomputed pairs on input transfer; hold occupancy while stage 2 is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_c0     <= '0;
            s1_c1     <= '0;
            s1_x_msb  <= 1'b0;
            s1_yy_msb <= 1'b0;
        end else begin
            s1_valid <= in_fire | (s1_valid & ~s2_adv);
            if (in_fire) begin
                s1_sum0   <= nxt_sum0;
                s1_sum1   <= b_sum1;
                s1_c0     <= nxt_c0;
                s1_c1     <= b_c1;
                s1_x_msb  <= x[WIDTH-1];
                s1_yy_msb <= yy[WIDTH-1];
            end
        end
    end

    // Stage 2 select chain: each block picks its pair by the resolved carry of the block below.
    logic [WIDTH-1:0] res;
    logic             rc;
    logic             msb_cin;
    logic             ovf_nxt;

    always_comb begin
        res = '0;
        rc  = 1'b0;
        for (int k = 0; k < int'(NB); k++) begin
            res[k*BLOCK_W +: BLOCK_W] = rc ? s1_sum1[k] : s1_sum0[k];
            rc                        = rc ? s1_c1[k]   : s1_c0[k];
        end
        msb_cin = s1_x_msb ^ s1_yy_msb ^ res[WIDTH-1];
        ovf_nxt = msb_cin ^ rc;
    end

    // Stage 2 result registers; frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s    <= res;
                cout <= rc;
                ovf  <= ovf_nxt;
            end
        end
    end

`ifndef SYNTHESIS
    // Results must stay put while a stalled output waits for the consumer.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable({s, cout, ovf}));
`endif

endmodule
